pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the single-cycle CPU. It consumes the branch-decision bit `MP` from the branch condition mux, together with decoder controls, and produces the next instruction address. It supports conditional relative branches, absolute jumps, and call/return through a 4-entry return-address stack (RAS). It also provides a halt/resume handshake and a saturating taken-branch counter. It sits between the decoder/branch mux and instruction memory.

## Interface
- `PC_WIDTH`, 16: width of PC, `OFFSET`, `TARGET`, and RAS entries.
- `RESET_VECTOR`, 0: PC value after reset.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: reset; one clock, reset is synchronous and active-high.
- `EN` input 1: advance enable; when 0, PC and RAS hold.
- `PL` input 1: current instruction is a branch or jump.
- `JB` input 1: with `PL`, 1 = unconditional jump, 0 = conditional branch.
- `MP` input 1: branch condition met, from the branch mux.
- `CALL` input 1: call; push return address, jump to `TARGET`.
- `RET` input 1: return; pop RAS into PC.
- `OFFSET` input PC_WIDTH: signed two's-complement branch displacement.
- `TARGET` input PC_WIDTH: absolute jump/call target.
- `HALT_REQ` input 1: request halt.
- `RESUME` input 1: leave halt.
- `PC` output PC_WIDTH: current instruction address (registered).
- `HALTED` output 1: state is HALTED.
- `TAKEN` output 1: the previous advancing cycle redirected the PC.
- `RAS_FULL` output 1: RAS holds 4 entries.
- `RAS_EMPTY` output 1: RAS holds 0 entries.
- `RAS_ERR` output 1: sticky; set on RAS overflow or underflow; cleared only by `RST`.
- `TAKEN_CNT` output 16: count of taken conditional branches; saturates at 16'hFFFF.

## Operation
- **States:** RUN and HALTED.
- **Advancing cycle:** state RUN and `EN`=1. Next-PC is chosen in this priority order:
  1. **`RET`:** if the RAS is non-empty, PC<=top and pop. If empty, PC<=PC+1 and set `RAS_ERR`.
  2. **`CALL`:** if the RAS is not full, push PC+1. If full, no push, RAS unchanged, set `RAS_ERR`. In both cases PC<=`TARGET`.
  3. **`PL`&`JB`:** PC<=`TARGET`.
  4. **`PL`&~`JB`&`MP`:** PC<=PC+`OFFSET`, modulo 2^PC_WIDTH. `TAKEN_CNT` increments unless it is already 16'hFFFF.
  5. **Otherwise:** PC<=PC+1, wrapping from all-ones to 0.
- **`TAKEN` (registered):** <=1 when rule 1 succeeds or rule 2, 3 or 4 fires; <=0 otherwise, including when `EN`=0 and in HALTED.
- **Ignored inputs:** `MP` is ignored unless `PL`&~`JB`. `CALL`/`RET` override `PL`.
- **Halt handshake:**
  - In RUN, `HALT_REQ`=1 on an advancing cycle: that cycle's PC update still happens, then the state goes to HALTED.
  - In RUN, `HALT_REQ`=1 with `EN`=0: the state goes to HALTED with PC held.
  - In HALTED: PC, RAS and counter all hold, and `EN`/`PL`/`CALL`/`RET` are ignored. `RESUME`=1 returns the state to RUN on the next edge.
  - `HALT_REQ` is ignored in HALTED. `RESUME` is ignored in RUN.
- **RAS:** 4 entries, LIFO, with a 3-bit occupancy count (0..4). Entries are not cleared on pop.
- **Reset values:**
  - PC = `RESET_VECTOR`; state RUN; `HALTED`=0.
  - `TAKEN`=0; `TAKEN_CNT`=0.
  - RAS count = 0, so `RAS_EMPTY`=1 and `RAS_FULL`=0; `RAS_ERR`=0.
  - Reset asserted mid-operation, including in HALTED, overrides all other inputs on that edge.

## Timing
- **PC:** next-PC logic is combinational from the inputs and current PC. `PC` updates on the edge ending an advancing cycle, so the latency is 1 cycle.
- **Registered status:** `HALTED`, `TAKEN`, `TAKEN_CNT`, `RAS_*` and `RAS_ERR` are registered and reflect the edge just taken.
- **Same-cycle CALL with RAS at 3 entries:** the push succeeds and `RAS_FULL`=1 after the edge.
- **Call then return:** a return on the cycle immediately after a call pops the just-pushed address.
- **`CALL` and `RET` together:** `RET` wins; no push occurs.

## Test plan
- **Reset and sequential advance:** `RST` for 1 cycle with `RESET_VECTOR`=16'h0010, then 3 advancing cycles with no controls -> PC goes 0010, 0011, 0012, 0013. `TAKEN`=0 throughout; `RAS_EMPTY`=1.
- **Conditional branch:** at PC=16'h0020 apply `PL`=1, `JB`=0.
  - `MP`=1, `OFFSET`=16'hFFF0 -> PC=16'h0010, `TAKEN`=1, `TAKEN_CNT`=1.
  - Repeat with `MP`=0 -> PC=PC+1 and the counter is unchanged.
- **Call/return nesting:** 4 calls at PC 0100, 0200, 0300, 0400 (targets 0200, 0300, 0400, 0500) -> `RAS_FULL`=1.
  - A 5th `CALL` -> `RAS_ERR`=1 and PC=`TARGET`.
  - Then 4 `RET` -> PC goes 0401, 0301, 0201, 0101.
  - A 5th `RET` -> PC+1, and `RAS_ERR` stays 1.
- **Halt/resume:** `HALT_REQ` together with a jump to 16'h0ABC -> PC=0ABC and `HALTED`=1.
  - 5 cycles with `EN`=1 and random controls -> PC stays 0ABC.
  - `RESUME` -> RUN on the next edge, then PC advances to 0ABD.
- **Wrap and saturation:**
  - PC=16'hFFFF with no branch -> PC=0.
  - Preload `TAKEN_CNT` to FFFE with taken branches, then 3 more taken branches -> FFFF held.
- **Reset mid-halt:** `RST` asserted while HALTED with the RAS holding 2 entries -> `HALTED`=0, PC=`RESET_VECTOR`, `RAS_EMPTY`=1, `RAS_ERR`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-cycle CPU.
// Produces the next instruction address from the decoder controls and the branch
// decision bit. Supports conditional relative branches, absolute jumps and call/return
// through a 4-entry return-address stack (RAS), a halt/resume handshake and a
// saturating taken-branch counter. Reset is synchronous and active-high.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   EN                advance enable (PC and RAS hold when low)
//   PL, JB, MP        branch/jump, jump-vs-branch select, branch condition met
//   CALL, RET         call (push PC+1, go to TARGET), return (pop RAS into PC)
//   OFFSET, TARGET    signed branch displacement, absolute jump/call target
//   HALT_REQ, RESUME  enter / leave the halted state
//   PC                current instruction address
//   HALTED, TAKEN     halted state, previous advancing cycle redirected the PC
//   RAS_FULL/EMPTY    RAS occupancy flags; RAS_ERR sticky over/underflow flag
//   TAKEN_CNT         saturating count of taken conditional branches
module pc_sequencer #(
  parameter int unsigned           PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                PL,
  input  logic                JB,
  input  logic                MP,
  input  logic                CALL,
  input  logic                RET,
  input  logic [PC_WIDTH-1:0] OFFSET,
  input  logic [PC_WIDTH-1:0] TARGET,
  input  logic                HALT_REQ,
  input  logic                RESUME,
  output logic [PC_WIDTH-1:0] PC,
  output logic                HALTED,
  output logic                TAKEN,
  output logic                RAS_FULL,
  output logic                RAS_EMPTY,
  output logic                RAS_ERR,
  output logic [15:0]         TAKEN_CNT
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  localparam logic [2:0] RasDepth = 3'd4;

  state_e              stateQ, stateD;
  logic [PC_WIDTH-1:0] pcQ, pcD;
  logic [PC_WIDTH-1:0] pcInc;
  logic                takenQ, takenD;
  logic [15:0]         cntQ, cntD;
  logic [2:0]          rasCntQ, rasCntD;
  logic                errQ, errD;
  logic                push;
  logic [PC_WIDTH-1:0] rasQ [4];
  logic [1:0]          topIdx;

  assign pcInc  = pcQ + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  // With 4 entries the low two bits wrap to 0, so subtracting 1 still lands on entry 3.
  assign topIdx = rasCntQ[1:0] - 2'd1;

  always_comb begin
    stateD  = stateQ;
    pcD     = pcQ;
    takenD  = 1'b0;
    cntD    = cntQ;
    rasCntD = rasCntQ;
    errD    = errQ;
    push    = 1'b0;
    unique case (stateQ)
      StRun: begin
        if (EN) begin
          if (RET) begin
            if (rasCntQ != 3'd0) begin
              pcD     = rasQ[topIdx];
              rasCntD = rasCntQ - 3'd1;
              takenD  = 1'b1;
            end else begin
              pcD  = pcInc;
              errD = 1'b1;
            end
          end else if (CALL) begin
            pcD    = TARGET;
            takenD = 1'b1;
            if (rasCntQ != RasDepth) begin
              push    = 1'b1;
              rasCntD = rasCntQ + 3'd1;
            end else begin
              errD = 1'b1;
            end
          end else if (PL && JB) begin
            pcD    = TARGET;
            takenD = 1'b1;
          end else if (PL && MP) begin
            pcD    = pcQ + OFFSET;
            takenD = 1'b1;
            if (cntQ != 16'hFFFF) begin
              cntD = cntQ + 16'd1;
            end
          end else begin
            pcD = pcInc;
          end
        end
        // The advancing update above still lands on the edge that enters HALTED.
        if (HALT_REQ) begin
          stateD = StHalted;
        end
      end
      StHalted: begin
        if (RESUME) begin
          stateD = StRun;
        end
      end
      default: stateD = StRun;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ  <= StRun;
      pcQ     <= RESET_VECTOR;
      takenQ  <= 1'b0;
      cntQ    <= 16'd0;
      rasCntQ <= 3'd0;
      errQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      takenQ  <= takenD;
      cntQ    <= cntD;
      rasCntQ <= rasCntD;
      errQ    <= errD;
    end
  end

  // Entries are never cleared; the occupancy count alone defines validity.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      rasQ[rasCntQ[1:0]] <= pcInc;
    end
  end

  assign PC        = pcQ;
  assign HALTED    = (stateQ == StHalted);
  assign TAKEN     = takenQ;
  assign RAS_FULL  = (rasCntQ == RasDepth);
  assign RAS_EMPTY = (rasCntQ == 3'd0);
  assign RAS_ERR   = errQ;
  assign TAKEN_CNT = cntQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps plus randomized
// stimulus, compared every cycle against a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [15:0] Rv = 16'h0010;

  logic        CLK = 1'b0;
  logic        RST, EN, PL, JB, MP, CALL, RET, HALT_REQ, RESUME;
  logic [15:0] OFFSET, TARGET;
  logic [15:0] PC, TAKEN_CNT;
  logic        HALTED, TAKEN, RAS_FULL, RAS_EMPTY, RAS_ERR;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [15:0] mPc;
  logic [15:0] mCnt;
  logic [15:0] mRas[$];
  bit          mHalted, mTaken, mErr;

  pc_sequencer #(
    .PC_WIDTH    (16),
    .RESET_VECTOR(Rv)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .PL       (PL),
    .JB       (JB),
    .MP       (MP),
    .CALL     (CALL),
    .RET      (RET),
    .OFFSET   (OFFSET),
    .TARGET   (TARGET),
    .HALT_REQ (HALT_REQ),
    .RESUME   (RESUME),
    .PC       (PC),
    .HALTED   (HALTED),
    .TAKEN    (TAKEN),
    .RAS_FULL (RAS_FULL),
    .RAS_EMPTY(RAS_EMPTY),
    .RAS_ERR  (RAS_ERR),
    .TAKEN_CNT(TAKEN_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".pc"},     PC,                  mPc);
    chk({tag, ".halted"}, 16'(HALTED),         16'(mHalted));
    chk({tag, ".taken"},  16'(TAKEN),          16'(mTaken));
    chk({tag, ".full"},   16'(RAS_FULL),       16'(mRas.size() == 4));
    chk({tag, ".empty"},  16'(RAS_EMPTY),      16'(mRas.size() == 0));
    chk({tag, ".err"},    16'(RAS_ERR),        16'(mErr));
    chk({tag, ".cnt"},    TAKEN_CNT,           mCnt);
  endtask

  // Behavioural model: applies the priority rules to the pre-edge state.
  task automatic modelStep();
    logic [15:0] nextPc;
    bit          tk;
    if (RST) begin
      mPc = Rv; mHalted = 0; mTaken = 0; mCnt = 0; mErr = 0;
      mRas.delete();
      return;
    end
    if (mHalted) begin
      mTaken = 0;
      if (RESUME) mHalted = 0;
      return;
    end
    tk     = 0;
    nextPc = mPc;
    if (EN) begin
      if (RET) begin
        if (mRas.size() > 0) begin
          nextPc = mRas.pop_back();
          tk     = 1;
        end else begin
          nextPc = mPc + 16'd1;
          mErr   = 1;
        end
      end else if (CALL) begin
        if (mRas.size() < 4) mRas.push_back(mPc + 16'd1);
        else mErr = 1;
        nextPc = TARGET;
        tk     = 1;
      end else if (PL && JB) begin
        nextPc = TARGET;
        tk     = 1;
      end else if (PL && MP) begin
        nextPc = mPc + OFFSET;
        tk     = 1;
        if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      end else begin
        nextPc = mPc + 16'd1;
      end
    end
    mPc    = nextPc;
    mTaken = tk;
    if (HALT_REQ) mHalted = 1;
  endtask

  task automatic drive(input logic rst, en, pl, jb, mp, call, ret, halt, resume,
                       input logic [15:0] off, tgt);
    RST = rst; EN = en; PL = pl; JB = jb; MP = mp; CALL = call; RET = ret;
    HALT_REQ = halt; RESUME = resume; OFFSET = off; TARGET = tgt;
  endtask

  // Advance one clock with the currently driven inputs; sample 1 time unit after the edge.
  task automatic tick(input string tag, input bit doCheck);
    modelStep();
    @(posedge CLK);
    #1;
    if (doCheck) checkAll(tag);
  endtask

  task automatic idle(input string tag);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    tick(tag, 1);
  endtask

  task automatic jump(input string tag, input logic [15:0] tgt);
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0, tgt);
    tick(tag, 1);
  endtask

  task automatic doCall(input string tag, input logic [15:0] tgt);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0, tgt);
    tick(tag, 1);
  endtask

  task automatic doRet(input string tag);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
    tick(tag, 1);
  endtask

  task automatic randomCycle(input string tag, input bit allowRst);
    drive(allowRst && ($urandom_range(0, 49) == 0),
          $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          16'($urandom), 16'($urandom));
    tick(tag, 1);
  endtask

  initial begin
    mPc = 'x; mCnt = 'x; mHalted = 0; mTaken = 0; mErr = 0;

    // Reset and sequential advance
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    tick("reset", 1);
    chk("reset_pc", PC, 16'h0010);
    idle("seq1"); chk("seq1_pc", PC, 16'h0011);
    idle("seq2"); chk("seq2_pc", PC, 16'h0012);
    idle("seq3"); chk("seq3_pc", PC, 16'h0013);

    // Conditional branch taken / not taken
    jump("to20", 16'h0020);
    drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 16'hFFF0, 16'h0);
    tick("br_taken", 1);
    chk("br_taken_pc", PC, 16'h0010);
    chk("br_taken_cnt", TAKEN_CNT, 16'd1);
    jump("to20b", 16'h0020);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'hFFF0, 16'h0);
    tick("br_not", 1);
    chk("br_not_pc", PC, 16'h0021);
    chk("br_not_cnt", TAKEN_CNT, 16'd1);

    // Call/return nesting with overflow and underflow
    jump("to100", 16'h0100);
    doCall("call1", 16'h0200);
    doCall("call2", 16'h0300);
    doCall("call3", 16'h0400);
    doCall("call4", 16'h0500);
    chk("call4_full", 16'(RAS_FULL), 16'd1);
    doCall("call5", 16'h0600);
    chk("call5_err", 16'(RAS_ERR), 16'd1);
    chk("call5_pc", PC, 16'h0600);
    doRet("ret1"); chk("ret1_pc", PC, 16'h0401);
    doRet("ret2"); chk("ret2_pc", PC, 16'h0301);
    doRet("ret3"); chk("ret3_pc", PC, 16'h0201);
    doRet("ret4"); chk("ret4_pc", PC, 16'h0101);
    doRet("ret5"); chk("ret5_pc", PC, 16'h0102);
    chk("ret5_err", 16'(RAS_ERR), 16'd1);

    // Halt with a jump, random controls while halted, then resume
    drive(0, 1, 1, 1, 0, 0, 0, 1, 0, 16'h0, 16'h0ABC);
    tick("halt", 1);
    chk("halt_pc", PC, 16'h0ABC);
    chk("halt_flag", 16'(HALTED), 16'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 0, 16'($urandom), 16'($urandom));
      tick("halted_rand", 1);
      chk("halted_pc", PC, 16'h0ABC);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    tick("resume", 1);
    chk("resume_flag", 16'(HALTED), 16'd0);
    idle("after_resume");
    chk("after_resume_pc", PC, 16'h0ABD);

    // PC wrap
    jump("toFFFF", 16'hFFFF);
    idle("wrap");
    chk("wrap_pc", PC, 16'h0000);

    // Randomized phase against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    tick("rand_reset", 1);
    for (int i = 0; i < 400; i++) randomCycle("rand", 1);

    // Counter saturation
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    tick("sat_reset", 1);
    for (int i = 0; i < 16'hFFFE; i++) begin
      drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 16'($urandom), 16'h0);
      tick("preload", 0);
    end
    checkAll("preload_done");
    chk("preload_cnt", TAKEN_CNT, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1, 0, 0, 0, 0, 16'($urandom), 16'h0);
      tick("sat", 1);
      chk("sat_cnt", TAKEN_CNT, 16'hFFFF);
    end

    // Reset while halted with two RAS entries
    doCall("mh_call1", 16'h1000);
    doCall("mh_call2", 16'h2000);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
    tick("mh_halt", 1);
    chk("mh_halted", 16'(HALTED), 16'd1);
    chk("mh_pc_held", PC, 16'h2000);
    drive(1, 1, 1, 1, 0, 1, 0, 1, 0, 16'h0, 16'h3000);
    tick("mh_reset", 1);
    chk("mh_reset_halted", 16'(HALTED), 16'd0);
    chk("mh_reset_pc", PC, 16'h0010);
    chk("mh_reset_empty", 16'(RAS_EMPTY), 16'd1);
    chk("mh_reset_err", 16'(RAS_ERR), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
